// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: loop-index sequencer for the radix-4 NTT datapath.
// Generates (p, k, j) tuples for NTT / INTT / PWM passes plus the read, butterfly-enable and
// write strobes that follow each issue through the BFU pipeline. One pass per start; done is
// raised only once the final write strobe has left the pipeline.
module ntt_seq_ctrl #(
  parameter int unsigned LOG_N   = 8,   // even, 4..12
  parameter int unsigned WEN_LAT = 14,  // issue-to-write latency, >= 2
  parameter int unsigned EN_LAT  = 1,   // issue-to-enable latency, 1..WEN_LAT
  localparam int unsigned P_MAX  = LOG_N / 2,
  localparam int unsigned CW     = LOG_N - 1,
  localparam int unsigned PW     = $clog2(P_MAX + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,        // asynchronous, active low
  input  logic          i_start,
  input  logic [1:0]    i_mode,
  input  logic          i_stall,
  output logic          o_busy,
  output logic          o_vld,
  output logic [PW-1:0] o_p,
  output logic [CW-1:0] o_k,
  output logic [CW-1:0] o_j,
  output logic          o_sel,
  output logic          o_ren,
  output logic          o_en,
  output logic          o_wen,
  output logic          o_done,
  output logic [1:0]    o_done_mode
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic [1:0] MODE_NTT  = 2'b00;
  localparam logic [1:0] MODE_PWM  = 2'b01;
  localparam logic [1:0] MODE_INTT = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  // Shift-amount width: must hold CW (<= 11) and 2*P_MAX-1.
  localparam int unsigned SW = PW + 2;
  localparam int unsigned DW = $clog2(WEN_LAT + 1);

  localparam logic [PW-1:0] P_LAST     = PW'(P_MAX);
  localparam logic [CW-1:0] ONES       = '1;
  localparam logic [SW-1:0] CW_S       = SW'(CW);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(WEN_LAT - 1);

  // Architectural state
  logic [1:0]         r_state;
  logic [1:0]         r_mode;
  logic               r_sel;
  logic [PW-1:0]      r_p;
  logic [CW-1:0]      r_k;
  logic [CW-1:0]      r_j;
  logic [DW-1:0]      r_cnt;
  logic [WEN_LAT-1:0] r_dly;

  // Next-state and decode wires
  logic [1:0]    w_state_nxt;
  logic [1:0]    w_mode_nxt;
  logic          w_sel_nxt;
  logic [PW-1:0] w_p_nxt;
  logic [CW-1:0] w_k_nxt;
  logic [CW-1:0] w_j_nxt;
  logic [DW-1:0] w_cnt_nxt;
  logic          w_vld;
  logic [SW-1:0] w_sh;
  logic [CW-1:0] w_jlim;
  logic [CW-1:0] w_klim;
  logic          w_jwrap;
  logic          w_kwrap;
  logic          w_stage_last;
  logic          w_last;

  // First stage of a pass: NTT walks stages downwards from P_MAX, INTT/PWM start at 0.
  function automatic logic [PW-1:0] first_p(input logic [1:0] mode);
    return (mode == MODE_NTT) ? P_LAST : '0;
  endfunction

  // Loop limits from p using shifts only. For p >= 1 with s = 2p-1:
  //   j_lim = 4^p/2 - 1   = 2^s - 1          = ONES >> (CW - s)
  //   k_lim = N/4^p - 1   = 2^(LOG_N-2p) - 1 = ONES >> s
  // Stage 0 is special: j fixed at 0, k covers N/2 entries.
  always_comb begin
    w_sh   = (SW'(r_p) << 1) - SW'(1);
    w_jlim = '0;
    w_klim = ONES;
    if (r_p != '0) begin
      w_jlim = ONES >> (CW_S - w_sh);
      w_klim = ONES >> w_sh;
    end
  end

  assign w_jwrap = (r_j == w_jlim);
  assign w_kwrap = (r_k == w_klim);

  // Identify the final stage of the pass for the latched mode.
  always_comb begin
    w_stage_last = 1'b1;
    case (r_mode)
      MODE_NTT:  w_stage_last = (r_p == '0);
      MODE_INTT: w_stage_last = (r_p == P_LAST);
      default:   w_stage_last = 1'b1;  // PWM is a single stage-0 sweep
    endcase
  end

  assign w_last = w_jwrap && w_kwrap && w_stage_last;
  assign w_vld  = (r_state == ST_RUN) && !i_stall;

  // FSM and loop-counter next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_sel_nxt   = r_sel;
    w_p_nxt     = r_p;
    w_k_nxt     = r_k;
    w_j_nxt     = r_j;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start && (i_mode != MODE_RSV)) begin
          w_state_nxt = ST_RUN;
          w_mode_nxt  = i_mode;
          w_sel_nxt   = (i_mode == MODE_INTT);
          w_p_nxt     = first_p(i_mode);
          w_k_nxt     = '0;
          w_j_nxt     = '0;
        end
      end
      ST_RUN: begin
        if (w_vld) begin
          if (w_last) begin
            // Park indices at their idle values while the pipeline drains.
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = '0;
            w_p_nxt     = first_p(r_mode);
            w_k_nxt     = '0;
            w_j_nxt     = '0;
          end else if (!w_jwrap) begin
            w_j_nxt = r_j + CW'(1);
          end else begin
            w_j_nxt = '0;
            if (!w_kwrap) begin
              w_k_nxt = r_k + CW'(1);
            end else begin
              w_k_nxt = '0;
              w_p_nxt = (r_mode == MODE_INTT) ? (r_p + PW'(1)) : (r_p - PW'(1));
            end
          end
        end
      end
      ST_DRAIN: begin
        // Stall has no effect here; the delay line flushes unconditionally.
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_cnt_nxt = r_cnt + DW'(1);
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_NTT;
      r_sel   <= 1'b0;
      r_p     <= P_LAST;
      r_k     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_sel   <= w_sel_nxt;
      r_p     <= w_p_nxt;
      r_k     <= w_k_nxt;
      r_j     <= w_j_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Strobe delay line: shifts every cycle so stalls travel down it as bubbles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_dly <= '0;
    end else begin
      r_dly <= {r_dly[WEN_LAT-2:0], w_vld};
    end
  end

  assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_vld       = w_vld;
  assign o_p         = r_p;
  assign o_k         = r_k;
  assign o_j         = r_j;
  assign o_sel       = r_sel;
  assign o_ren       = r_dly[0];
  assign o_en        = r_dly[EN_LAT-1];
  assign o_wen       = r_dly[WEN_LAT-1];
  assign o_done      = (r_state == ST_FIN);
  assign o_done_mode = (r_state == ST_FIN) ? r_mode : 2'b00;

endmodule

// File: doc/ntt_seq_ctrl.md
# ntt_seq_ctrl

Parametrised sequencer for the radix-4 NTT datapath. It generates the (p, k, j) loop indices for NTT, INTT and point-wise multiply (PWM) passes, and the read, butterfly-enable and write strobes that go with them. Unlike the fixed 256-point level-driven controller, it is configured for any even log2 transform size. Each pass starts on a start/busy/done handshake, can be stalled cycle by cycle, and raises done only after the last write has left the butterfly pipeline. It sits between the top-level command logic and the BFU array, memory banks and twiddle ROM address generator.

## Interface
Parameters:
- LOG_N, 8, log2 of transform length; even, range 4..12. N = 2^LOG_N.
- WEN_LAT, 14, cycles from issue to write strobe (BFU pipeline depth); ≥2.
- EN_LAT, 1, cycles from issue to butterfly enable; 1 ≤ EN_LAT ≤ WEN_LAT.

Derived constants: P_MAX = LOG_N/2, CW = LOG_N-1, PW = clog2(P_MAX+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  00 NTT, 01 PWM, 10 INTT, 11 reserved; sampled with start.
- stall  in  1  freezes issue for this cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- vld  out  1  issue strobe; p, k, j are valid when this is high.
- p  out  PW  stage index.
- k  out  CW  block index.
- j  out  CW  intra-block index.
- sel  out  1  1 during INTT; held at the last accepted mode until the next start.
- ren  out  1  vld delayed 1 cycle.
- en  out  1  vld delayed EN_LAT cycles.
- wen  out  1  vld delayed WEN_LAT cycles.
- done  out  1  one-cycle pulse at the end of a pass.
- done_mode  out  2  mode of the finished pass; valid while done is high.

## Operation
- States are IDLE, RUN, DRAIN and FIN.
- IDLE → RUN on start with mode ≠ 11. The controller latches mode and loads the first tuple.
  - start with mode = 11 is ignored.
  - start outside IDLE is ignored.
- RUN:
  - vld = !stall.
  - Counters advance only when vld = 1.
  - The cycle that issues the final tuple moves the controller to DRAIN.
- DRAIN:
  - The controller counts WEN_LAT cycles while the delay lines flush. Stall is ignored here.
  - After WEN_LAT cycles it moves to FIN.
- FIN: done = 1 for one cycle, then IDLE. busy drops in the same cycle done rises.
- Stage p ≥ 1:
  - j runs 0..(4^p/2 − 1), inner loop.
  - k runs 0..(N/4^p − 1), outer loop.
- Stage p = 0: j = 0 and k runs 0..N/2−1.
- Every stage is N/2 issue cycles.
- NTT stage order is P_MAX, P_MAX−1, …, 0. The final tuple is (0, N/2−1, 0).
- INTT stage order is 0, 1, …, P_MAX. The final tuple is (P_MAX, 0, 4^P_MAX/2 − 1).
- PWM is a single pass with p = 0, j = 0 and k running 0..N/2−1.
- Wrap rules:
  - When j reaches its limit, j → 0 and k increments.
  - When k also reaches its limit, k → 0 and the stage advances.
  - Limits are computed from p with shifts only (no multipliers).
  - All compares are at full CW width.
- Delay lines are plain shift registers that shift every cycle. A stall therefore appears as a bubble in ren, en and wen, exactly WEN_LAT cycles later on wen.
- Outside RUN, p/k/j hold their reset values: p = P_MAX for NTT, 0 otherwise, and k = j = 0.

## Timing
- Reset (rst = 0, asynchronous) values:
  - State = IDLE, sel = 0, busy = vld = ren = en = wen = done = 0, done_mode = 00, p = P_MAX, k = j = 0.
  - All delay-line stages clear.
- Reset mid-pass aborts immediately. No done is produced and the write strobe does not complete.
- start is accepted in cycle t:
  - busy = 1 from t+1.
  - The first vld (if not stalled) is at t+1, carrying the first tuple.
- Issue at cycle u gives ren at u+1, en at u+EN_LAT and wen at u+WEN_LAT.
- With no stalls, the final issue is at t + (P_MAX+1)·N/2 for NTT/INTT and t + N/2 for PWM.
- If the last issue is at cycle L, the last wen is at L+WEN_LAT and done is at L+WEN_LAT+1.
- Back-to-back passes: a start in the same cycle as done is ignored. The earliest accepted start is the cycle after done.
- Stall asserted at the wrap cycle holds the pre-wrap tuple. The wrap happens on the next unstalled cycle.

## Test plan
- NTT, LOG_N=8, WEN_LAT=14, no stall:
  - vld runs 640 consecutive cycles, starting with (4, 0, 0).
  - Issue 128 is (3, 0, 0). Issue 639 is (0, 127, 0).
  - done comes 15 cycles after the last vld, with done_mode = 00.
- INTT, LOG_N=8: the first tuple is (0, 0, 0), issue 128 is (1, 0, 0), the last tuple is (4, 0, 127), and sel = 1 throughout.
- PWM with stall = 1 on every third cycle:
  - k runs 0..127 with no skips or repeats.
  - Exactly 128 wen pulses appear, each with the same bubble pattern shifted by 14 cycles.
- Boundary, LOG_N=4:
  - Stage p=2 is j 0..7, k 0.
  - Stage p=1 is j 0..1, k 0..3.
  - Stage p=0 is k 0..7.
  - That gives 24 issues in total.
- rst pulsed low at issue 300 of an NTT pass: all outputs are at reset values within the reset cycle and no done follows. A new start then produces a clean pass.
- Two illegal starts: start with mode = 11 in IDLE and start while busy are both ignored, with busy, vld and done unchanged.
